dvsd_wt8216m_arb: RTL and testbench

Round-robin scheduler that shares one 8x8 unsigned Wallace-tree multiplier among NREQ requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake, drives the shared multiplier's operand inputs, and waits out the multiplier's fixed latency. It then returns the 16-bit product tagged with the requester index. It sits between client logic and the single `dvsd_8216m*` multiplier instance, which is combinational or pipelined.

---
 rtl/dvsd_wt8216m_arb.sv | 146 ++++++++++++++
 tb/tb_dvsd_wt8216m_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvsd_wt8216m_arb.sv
// Round-robin scheduler sharing one 8x8 unsigned multiplier among NREQ requesters.
// One operation in flight: grant in IDLE, wait out MUL_LAT in WAIT, hold result in RESP.
module dvsd_wt8216m_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 0,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_m,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_m,
    output logic              busy
);

    localparam int unsigned SW   = IDW + 1;
    localparam int unsigned CNTW = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [IDW-1:0]  r_last_gnt;
    logic [IDW-1:0]  w_gnt;
    logic [IDW-1:0]  w_cand;
    logic [SW-1:0]   w_sum;
    logic            w_found;
    logic            w_accept;
    logic [NREQ-1:0] w_ready;
    logic [CNTW-1:0] r_cnt;
    logic [7:0]      r_mul_a;
    logic [7:0]      r_mul_b;
    logic [7:0]      w_sel_a;
    logic [7:0]      w_sel_b;
    logic [15:0]     r_rsp_m;
    logic [IDW-1:0]  r_rsp_id;

    // Round-robin search starting one past the last grant, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_sum = SW'(r_last_gnt) + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            w_cand = IDW'(w_sum);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_gnt) begin
                w_sel_a = req_a[i*8 +: 8];
                w_sel_b = req_b[i*8 +: 8];
            end
        end
    end

    // Next-state and grant decode
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ready[w_gnt] = 1'b1;
                    w_accept       = 1'b1;
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands hold between operations so the multiplier stays quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= IDW'(NREQ - 1);
            r_cnt      <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_rsp_m    <= '0;
            r_rsp_id   <= '0;
        end else if (w_accept) begin
            r_mul_a    <= w_sel_a;
            r_mul_b    <= w_sel_b;
            r_rsp_id   <= w_gnt;
            r_last_gnt <= w_gnt;
            r_cnt      <= CNTW'(MUL_LAT);
        end else if (r_state == S_WAIT) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNTW'(1);
            end else begin
                r_rsp_m <= mul_m;
            end
        end
    end

    assign req_ready = w_ready;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_m     = r_rsp_m;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_dvsd_wt8216m_arb.sv
// Directed bench for dvsd_wt8216m_arb: one instance with a combinational multiplier
// (MUL_LAT=0) and one with a 3-stage pipelined multiplier (MUL_LAT=3).
module tb_dvsd_wt8216m_arb;

    logic        clk;
    logic        rst;

    logic [3:0]  v0, rdy0;
    logic [31:0] a0, b0;
    logic [7:0]  ma0, mb0;
    logic [15:0] mm0, m0;
    logic        rv0, rr0, busy0;
    logic [1:0]  id0;

    logic [3:0]  v3, rdy3;
    logic [31:0] a3, b3;
    logic [7:0]  ma3, mb3;
    logic [15:0] mm3, m3;
    logic        rv3, rr3, busy3;
    logic [1:0]  id3;
    logic [15:0] p1, p2, p3;

    int n_chk;
    int n_err;

    dvsd_wt8216m_arb #(.NREQ(4), .MUL_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_a(a0), .req_b(b0),
        .mul_a(ma0), .mul_b(mb0), .mul_m(mm0), .rsp_valid(rv0), .rsp_ready(rr0),
        .rsp_id(id0), .rsp_m(m0), .busy(busy0)
    );

    dvsd_wt8216m_arb #(.NREQ(4), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_a(a3), .req_b(b3),
        .mul_a(ma3), .mul_b(mb3), .mul_m(mm3), .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_id(id3), .rsp_m(m3), .busy(busy3)
    );

    // Multiplier models: combinational, and three register stages
    assign mm0 = 16'(ma0) * 16'(mb0);
    always @(posedge clk) begin
        p1 <= 16'(ma3) * 16'(mb3);
        p2 <= p1;
        p3 <= p2;
    end
    assign mm3 = p3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        rst = 1'b1;
        v0 = '0; v3 = '0; rr0 = 1'b1; rr3 = 1'b1;
        a0 = '0; b0 = '0; a3 = '0; b3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        v0 = '0; v3 = '0; rr0 = 1'b1; rr3 = 1'b1;
        a0 = '0; b0 = '0; a3 = '0; b3 = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_chk++; if (rdy0 !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", rdy0); end
        n_chk++; if (rv0 !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rv0); end
        n_chk++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_chk++; if ({ma0, mb0} !== 16'h0000) begin n_err++; $display("FAIL reset_operands: got %h want 0000", {ma0, mb0}); end
        n_chk++; if ({m0, id0} !== 18'h0) begin n_err++; $display("FAIL reset_rsp: got %h want 0", {m0, id0}); end
        n_chk++; if ({busy3, rv3} !== 2'b00) begin n_err++; $display("FAIL reset_dut3: got %b want 00", {busy3, rv3}); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic test_single;
        int n;
        a0[23:16] = 8'hFB; b0[23:16] = 8'h7E;
        v0 = 4'b0100;
        #1;
        n_chk++; if (rdy0 !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", rdy0); end
        @(posedge clk); #1;
        v0 = '0;
        n = 1;
        n_chk++; if ({ma0, mb0} !== 16'hFB7E) begin n_err++; $display("FAIL single_operands: got %h want FB7E", {ma0, mb0}); end
        n_chk++; if ({busy0, rv0, rdy0} !== 6'b100000) begin n_err++; $display("FAIL single_wait: got %b want 100000", {busy0, rv0, rdy0}); end
        while (!rv0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++; if (n !== 2) begin n_err++; $display("FAIL single_latency: got %0d want 2", n); end
        n_chk++; if (m0 !== 16'h7B8A) begin n_err++; $display("FAIL single_product: got %h want 7B8A", m0); end
        n_chk++; if (id0 !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", id0); end
        @(posedge clk); #1;
        n_chk++; if ({busy0, rv0} !== 2'b00) begin n_err++; $display("FAIL single_idle: got %b want 00", {busy0, rv0}); end
    endtask

    task automatic test_pipelined;
        int n;
        a3[7:0] = 8'hFF; b3[7:0] = 8'hFF;
        v3 = 4'b0001;
        #1;
        n_chk++; if (rdy3 !== 4'b0001) begin n_err++; $display("FAIL pipe_grant0: got %b want 0001", rdy3); end
        @(posedge clk); #1;
        v3 = '0;
        n = 1;
        while (!rv3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++; if (n !== 5) begin n_err++; $display("FAIL pipe_latency0: got %0d want 5", n); end
        n_chk++; if ({m3, id3} !== {16'hFE01, 2'd0}) begin n_err++; $display("FAIL pipe_max: got %h/%0d want FE01/0", m3, id3); end
        @(posedge clk); #1;
        a3[15:8] = 8'h00; b3[15:8] = 8'hA5;
        v3 = 4'b0010;
        #1;
        n_chk++; if (rdy3 !== 4'b0010) begin n_err++; $display("FAIL pipe_grant1: got %b want 0010", rdy3); end
        @(posedge clk); #1;
        v3 = '0;
        n = 1;
        while (!rv3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++; if (n !== 5) begin n_err++; $display("FAIL pipe_latency1: got %0d want 5", n); end
        n_chk++; if ({m3, id3} !== {16'h0000, 2'd1}) begin n_err++; $display("FAIL pipe_zero: got %h/%0d want 0000/1", m3, id3); end
        @(posedge clk); #1;
    endtask

    task automatic test_fairness;
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        int o;
        do_reset();
        a0 = 32'h04030201; b0 = 32'h04030201;
        v0 = 4'hF;
        #1;
        // Grant at cycle 3k, WAIT at 3k+1, RESP at 3k+2
        for (int cyc = 0; cyc < 18; cyc++) begin
            o = exp_order[cyc / 3];
            if (cyc % 3 == 0) begin
                n_chk++; if (rdy0 !== 4'(1 << o)) begin n_err++; $display("FAIL fair_grant c%0d: got %b want %b", cyc, rdy0, 4'(1 << o)); end
            end else begin
                n_chk++; if (rdy0 !== 4'b0000) begin n_err++; $display("FAIL fair_nogrant c%0d: got %b want 0000", cyc, rdy0); end
            end
            if (cyc % 3 == 2) begin
                n_chk++; if ({rv0, id0, m0} !== {1'b1, 2'(o), 16'((o + 1) * (o + 1))}) begin
                    n_err++; $display("FAIL fair_rsp c%0d: got v%b id%0d m%h want v1 id%0d m%h", cyc, rv0, id0, m0, o, 16'((o + 1) * (o + 1)));
                end
            end
            @(posedge clk); #2;
        end
        v0 = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        do_reset();
        a0[15:8] = 8'h12; b0[15:8] = 8'h34;
        rr0 = 1'b0;
        v0 = 4'b1010;
        #1;
        n_chk++; if (rdy0 !== 4'b0010) begin n_err++; $display("FAIL bp_grant: got %b want 0010", rdy0); end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            n_chk++; if ({rv0, id0, m0, rdy0} !== {1'b1, 2'd1, 16'h03A8, 4'b0000}) begin
                n_err++; $display("FAIL bp_hold c%0d: got v%b id%0d m%h rdy%b want v1 id1 m03A8 rdy0000", i, rv0, id0, m0, rdy0);
            end
            @(posedge clk); #1;
        end
        rr0 = 1'b1;
        #1;
        n_chk++; if ({rv0, rdy0} !== 5'b10000) begin n_err++; $display("FAIL bp_handshake: got %b want 10000", {rv0, rdy0}); end
        @(posedge clk); #1;
        n_chk++; if ({rv0, rdy0} !== 5'b01000) begin n_err++; $display("FAIL bp_next_grant: got %b want 01000", {rv0, rdy0}); end
        v0 = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_skip_wrap;
        do_reset();
        v0 = 4'b1000;
        #1;
        n_chk++; if (rdy0 !== 4'b1000) begin n_err++; $display("FAIL wrap_grant3: got %b want 1000", rdy0); end
        @(posedge clk); #1;
        v0 = '0;
        repeat (3) @(posedge clk);
        #1;
        v0 = 4'b0010;
        #1;
        n_chk++; if (rdy0 !== 4'b0010) begin n_err++; $display("FAIL wrap_skip: got %b want 0010", rdy0); end
        @(posedge clk); #1;
        v0 = '0;
        repeat (3) @(posedge clk);
        #1;
        v0 = 4'b0011;
        #1;
        n_chk++; if (rdy0 !== 4'b0001) begin n_err++; $display("FAIL wrap_to_zero: got %b want 0001", rdy0); end
        @(posedge clk); #1;
        v0 = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset;
        int seen;
        do_reset();
        a0[23:16] = 8'h55; b0[23:16] = 8'h02;
        v0 = 4'b0100;
        #1;
        @(posedge clk); #1;
        n_chk++; if ({busy0, rv0, ma0} !== {2'b10, 8'h55}) begin n_err++; $display("FAIL ar_wait: got %b/%h want 10/55", {busy0, rv0}, ma0); end
        #2;
        rst = 1'b1;
        v0 = '0;
        #1;
        n_chk++; if ({busy0, rv0, rdy0} !== 6'b000000) begin n_err++; $display("FAIL ar_state: got %b want 000000", {busy0, rv0, rdy0}); end
        n_chk++; if ({ma0, mb0, m0, id0} !== 34'h0) begin n_err++; $display("FAIL ar_regs: got %h/%h/%h/%0d want 0", ma0, mb0, m0, id0); end
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rv0 !== 1'b0) seen++;
        end
        n_chk++; if (seen !== 0) begin n_err++; $display("FAIL ar_stale: got %0d rsp_valid cycles want 0", seen); end
        v0 = 4'hF;
        #1;
        n_chk++; if (rdy0 !== 4'b0001) begin n_err++; $display("FAIL ar_first_grant: got %b want 0001", rdy0); end
        v0 = '0;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_pipelined();
        test_fairness();
        test_backpressure();
        test_skip_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
